// File: rtl/freelist_dec_pkg.sv
// Shared sizing for the free-list tracker: entry count, index width and
// the width of the free-entry population count.
package freelist_dec_pkg;

    localparam int FL_EN_SIZE = 5;
    localparam int FL_DE_SIZE = 2 ** FL_EN_SIZE;
    localparam int FL_CNT_W   = FL_EN_SIZE + 1;

endpackage

// File: rtl/freelist_dec_dec_onehot.sv
// Encoded-index to one-hot decoder; a disabled port decodes to all-zero.
module dec_onehot
    import freelist_dec_pkg::*;
#(
    parameter int EN_SIZE = FL_EN_SIZE,
    parameter int DE_SIZE = FL_DE_SIZE
) (
    input  logic [EN_SIZE-1:0] idx,
    input  logic               en,
    output logic [DE_SIZE-1:0] onehot
);

    // Single bit set at the indexed position when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/freelist_dec.sv
// Free-list bitmap for a two-way allocator with two release ports.
// Requests are validated against the registered mask; illegal or duplicate
// requests are dropped per port and raise a sticky error flag.
module freelist_dec
    import freelist_dec_pkg::*;
#(
    parameter int DE_SIZE = FL_DE_SIZE,
    parameter int EN_SIZE = FL_EN_SIZE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc_en_high,
    input  logic [EN_SIZE-1:0] alloc_idx_high,
    input  logic               alloc_en_low,
    input  logic [EN_SIZE-1:0] alloc_idx_low,
    input  logic               rel_en_a,
    input  logic [EN_SIZE-1:0] rel_idx_a,
    input  logic               rel_en_b,
    input  logic [EN_SIZE-1:0] rel_idx_b,
    output logic [DE_SIZE-1:0] free_mask,
    output logic [EN_SIZE:0]   free_count,
    output logic               empty,
    output logic               almost_empty,
    output logic               err
);

    logic [DE_SIZE-1:0] hot_ah, hot_al, hot_ra, hot_rb;
    logic [DE_SIZE-1:0] alloc_legal_hot, rel_legal_hot;
    logic [DE_SIZE-1:0] free_mask_d, free_mask_q;
    logic [EN_SIZE:0]   free_count_d, free_count_q;
    logic               err_d, err_q;
    logic               bad_ah, bad_al, bad_ra, bad_rb, dup_alloc, dup_rel;

    dec_onehot #(.EN_SIZE(EN_SIZE), .DE_SIZE(DE_SIZE)) u_dec_ah (
        .idx(alloc_idx_high), .en(alloc_en_high), .onehot(hot_ah));
    dec_onehot #(.EN_SIZE(EN_SIZE), .DE_SIZE(DE_SIZE)) u_dec_al (
        .idx(alloc_idx_low), .en(alloc_en_low), .onehot(hot_al));
    dec_onehot #(.EN_SIZE(EN_SIZE), .DE_SIZE(DE_SIZE)) u_dec_ra (
        .idx(rel_idx_a), .en(rel_en_a), .onehot(hot_ra));
    dec_onehot #(.EN_SIZE(EN_SIZE), .DE_SIZE(DE_SIZE)) u_dec_rb (
        .idx(rel_idx_b), .en(rel_en_b), .onehot(hot_rb));

    // Legality filtering against the current mask, next mask and error update
    always_comb begin
        // An alloc hit is only legal on a free bit, a release only on a used bit,
        // so masking the one-hots drops illegal ports and merges duplicates.
        alloc_legal_hot = (hot_ah | hot_al) & free_mask_q;
        rel_legal_hot   = (hot_ra | hot_rb) & ~free_mask_q;
        bad_ah    = alloc_en_high && ((hot_ah & free_mask_q) == '0);
        bad_al    = alloc_en_low  && ((hot_al & free_mask_q) == '0);
        bad_ra    = rel_en_a && ((hot_ra & ~free_mask_q) == '0);
        bad_rb    = rel_en_b && ((hot_rb & ~free_mask_q) == '0);
        dup_alloc = alloc_en_high && alloc_en_low && (alloc_idx_high == alloc_idx_low);
        dup_rel   = rel_en_a && rel_en_b && (rel_idx_a == rel_idx_b);
        free_mask_d = (free_mask_q & ~alloc_legal_hot) | rel_legal_hot;
        err_d = err_q | bad_ah | bad_al | bad_ra | bad_rb | dup_alloc | dup_rel;
    end

    // Popcount of the next mask so the count lands on the same edge as the mask
    always_comb begin
        free_count_d = '0;
        for (int i = 0; i < DE_SIZE; i++) begin
            free_count_d = free_count_d + {{EN_SIZE{1'b0}}, free_mask_d[i]};
        end
    end

    // State registers; reset marks every entry free and clears the error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_mask_q  <= '1;
            free_count_q <= (EN_SIZE + 1)'(DE_SIZE);
            err_q        <= 1'b0;
        end else begin
            free_mask_q  <= free_mask_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
        end
    end

    assign free_mask    = free_mask_q;
    assign free_count   = free_count_q;
    assign err          = err_q;
    assign empty        = (free_count_q == '0);
    assign almost_empty = (free_count_q < (EN_SIZE + 1)'(2));

endmodule

// File: doc/freelist_dec.md
FREELIST_DEC -- requirements
Module: freelist_dec

Interface
REQ-001 Parameter DE_SIZE, default 32: number of tracked entries, and width of the one-hot/bitmask domain.
REQ-002 Parameter EN_SIZE, default 5: width of an encoded entry index; DE_SIZE SHALL equal 2**EN_SIZE.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 alloc_en_high  in  1  allocate the entry named by alloc_idx_high.
REQ-006 alloc_idx_high  in  EN_SIZE  encoded index, high-priority grant from the priority encoder.
REQ-007 alloc_en_low  in  1  allocate the entry named by alloc_idx_low.
REQ-008 alloc_idx_low  in  EN_SIZE  encoded index, low-priority grant.
REQ-009 rel_en_a / rel_en_b  in  1 each  release (retire) requests, two ports.
REQ-010 rel_idx_a / rel_idx_b  in  EN_SIZE each  encoded indices being released.
REQ-011 free_mask  out  DE_SIZE  registered bitmap, 1 = entry free; feeds the priority encoder.
REQ-012 free_count  out  EN_SIZE+1  registered population count of free_mask (0..DE_SIZE).
REQ-013 empty  out  1  high when free_count == 0.
REQ-014 almost_empty  out  1  high when free_count < 2 (fewer than a full two-way allocation).
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Each enabled encoded index SHALL be decoded to a DE_SIZE-bit one-hot vector; disabled ports decode to all-zero.
REQ-017 An alloc is legal only if its bit is 1 in the current free_mask; a release is legal only if its bit is 0.
REQ-018 Next mask SHALL be (free_mask & ~legal_alloc_hot) | legal_rel_hot, registered at the next rising edge (1-cycle latency).
REQ-019 free_count SHALL be registered in the same edge as free_mask and always equal popcount(free_mask).
REQ-020 empty and almost_empty SHALL be derived combinationally from the registered free_count only.
REQ-021 An illegal alloc or illegal release SHALL be ignored (no mask change for that port) and SHALL set err.
REQ-022 alloc_en_high and alloc_en_low both asserted with equal indices: the entry is cleared once, count drops by 1, and err is set.
REQ-023 rel_en_a and rel_en_b both asserted with equal legal indices: the entry is set once, count rises by 1, and err is set.
REQ-024 Alloc and release of the same index in one cycle cannot both be legal; each is judged per REQ-017 against the current mask.
REQ-025 Up to two allocs and two releases on distinct legal indices SHALL all take effect in the same cycle; net count change lies in -2..+2.
REQ-026 Once set, err SHALL remain high until reset.

Reset
REQ-027 While reset is high: free_mask = all ones, free_count = DE_SIZE, empty = 0, almost_empty = 0, err = 0.
REQ-028 Reset asserted mid-cycle SHALL take effect immediately, discarding any requests in flight; the first update after deassertion uses the reset mask.

Structure
REQ-029 DE_SIZE and EN_SIZE SHALL live in the shared project package, together with the width of free_count (EN_SIZE+1).
REQ-030 The EN_SIZE-to-DE_SIZE one-hot decoder SHALL be a sub-module named dec_onehot (inputs idx and en, output one-hot), instantiated four times.
REQ-031 The popcount SHALL be computed on the next-mask value, so free_count needs no extra cycle.

Verification
REQ-032 Reset -> free_mask = 32'hffff_ffff, free_count = 32, empty = 0, almost_empty = 0, err = 0.
REQ-033 After reset, alloc high = 31 and low = 0, no release -> next cycle free_mask = 32'h7fff_fffe, free_count = 30.
REQ-034 From 32'h0f00_0000: alloc 27/24, release 4/5 -> free_mask = 32'h0600_0030, free_count = 4.
REQ-035 Alloc the remaining entries down to 1 free -> almost_empty = 1, empty = 0; alloc the last entry -> empty = 1, free_count = 0.
REQ-036 free_mask = 32'h0000_0010: release 4 (double free) plus alloc 7 (not free) -> mask unchanged, err = 1 and stays 1 for later legal traffic.
REQ-037 Assert reset asynchronously between edges during a two-alloc cycle -> outputs return to the REQ-027 values at once, and no allocation is applied.
